// File: rtl/hilo_muldiv_unit_pkg.sv
// hilo_muldiv_unit_pkg: opcodes, FSM encoding and flag indices shared with the ALU
package hilo_muldiv_unit_pkg;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int FLAG_DIV0 = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_WIDE = 2;
    localparam int FLAG_ZERO = 3;
    typedef logic [3:0] muldiv_flags_t;
endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: request, HI/LO write and result bundle between pipeline and mul/div unit
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       operation;
    logic [1:0]       sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] outHI;
    logic [WIDTH-1:0] outLO;
    logic             busy;
    logic             done;
    logic [3:0]       flags;
    modport master (
        output start, operation, sign, A, B, wr_hi, wr_lo, wr_data,
        input  outHI, outLO, busy, done, flags
    );
    modport slave (
        input  start, operation, sign, A, B, wr_hi, wr_lo, wr_data,
        output outHI, outLO, busy, done, flags
    );
endinterface

// File: rtl/hilo_muldiv_unit_core.sv
// muldiv_magnitude_core: unsigned iterative shift-add multiplier / restoring divider
module muldiv_magnitude_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] opb;
    logic             div;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum, t, shl, diff;
    // one step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, opb};
        t    = lo[0] ? sum : {1'b0, hi};
        shl  = {hi, lo[WIDTH-1]};
        diff = shl - {1'b0, opb};
    end
    assign last = cnt == CW'(WIDTH - 1);
    // {hi,lo} is the product accumulator or the remainder/quotient pair
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi  <= '0;
            lo  <= '0;
            opb <= '0;
            div <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            opb <= b;
            div <= is_div;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            hi  <= div ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : t[WIDTH:1];
            lo  <= div ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {t[0], lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MULT/DIV sequencer with sign handling and the architectural HI/LO pair
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset_n,
    hilo_muldiv_unit_if.slave bus
);
    logic [1:0]         state;
    logic               is_div, sgn, neg_q, neg_r, dz, ovf;
    logic               accept, by_zero, run, last;
    logic [WIDTH-1:0]   a_mag, b_mag, core_a, core_hi, core_lo;
    logic [WIDTH-1:0]   q_fix, r_fix, res_hi, res_lo, hi_ext, hi_q, lo_q;
    logic [2*WIDTH-1:0] p_mag, prod;
    muldiv_flags_t      res_flags, flags_q;
    logic               unused_sign;
    assign unused_sign = bus.sign[1];
    // request decode, operand magnitudes and signed fix-up of the raw core result
    always_comb begin
        accept  = state == S_IDLE && bus.start && (bus.operation == OP_MULT || bus.operation == OP_DIV);
        by_zero = bus.operation == OP_DIV && bus.B == '0;
        run     = state == S_CALC;
        a_mag   = bus.sign[0] && bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag   = bus.sign[0] && bus.B[WIDTH-1] ? -bus.B : bus.B;
        core_a  = by_zero ? bus.A : a_mag;
        p_mag   = {core_hi, core_lo};
        prod    = neg_q ? -p_mag : p_mag;
        q_fix   = neg_q ? -core_lo : core_lo;
        r_fix   = neg_r ? -core_hi : core_hi;
        res_hi  = dz ? core_lo : is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
        res_lo  = dz ? '1 : is_div ? q_fix : prod[WIDTH-1:0];
        hi_ext  = sgn ? {WIDTH{res_lo[WIDTH-1]}} : '0;
        res_flags = '0;
        res_flags[FLAG_DIV0] = dz;
        res_flags[FLAG_OVF]  = ovf;
        res_flags[FLAG_WIDE] = !is_div && res_hi != hi_ext;
        res_flags[FLAG_ZERO] = res_hi == '0 && res_lo == '0;
    end
    muldiv_magnitude_core #(.WIDTH(WIDTH)) core (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (accept),
        .run    (run),
        .is_div (bus.operation == OP_DIV),
        .a      (core_a),
        .b      (b_mag),
        .hi     (core_hi),
        .lo     (core_lo),
        .last   (last)
    );
    // sequencing; divide-by-zero skips the iterations, HI/LO/flags load on entry to DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            is_div  <= 1'b0;
            sgn     <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_div <= bus.operation == OP_DIV;
                        sgn    <= bus.sign[0];
                        neg_q  <= bus.sign[0] && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_r  <= bus.sign[0] && bus.A[WIDTH-1];
                        dz     <= by_zero;
                        ovf    <= bus.sign[0] && bus.operation == OP_DIV &&
                                  bus.A == {1'b1, {(WIDTH-1){1'b0}}} && bus.B == '1;
                        state  <= by_zero ? S_FIX : S_CALC;
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                S_CALC: if (last) state <= S_FIX;
                S_FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    flags_q <= res_flags;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign bus.outHI = hi_q;
    assign bus.outLO = lo_q;
    assign bus.flags = flags_q;
    assign bus.busy  = state != S_IDLE;
    assign bus.done  = state == S_DONE;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors with a result scoreboard for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  flags;
        int          lat;
        int          t0;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   applied = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t e;
    hilo_muldiv_unit_if #(.WIDTH(32)) bus();
    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction
    // monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("hi", bus.outHI, e.hi);
                chk("lo", bus.outLO, e.lo);
                chk("flags", bus.flags, e.flags);
                chk("latency", cyc - e.t0 + 1, e.lat);
                chk("busy_at_done", bus.busy, 1);
            end
        end
    end
    // called at a negedge; the start is sampled at the following posedge
    task automatic issue(input logic [3:0] op, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic [3:0] ef, input int elat);
        exp_t x;
        x.hi = eh;
        x.lo = el;
        x.flags = ef;
        x.lat = elat;
        x.t0 = cyc + 1;
        sb.push_back(x);
        bus.start = 1'b1;
        bus.operation = op;
        bus.sign = s;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask
    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask
    task automatic run_op(input logic [3:0] op, input logic [1:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic [3:0] ef, input int elat);
        issue(op, s, a, b, eh, el, ef, elat);
        wait_sb();
    endtask
    initial begin
        bus.start = 1'b0;
        bus.operation = 4'd0;
        bus.sign = 2'b00;
        bus.A = '0;
        bus.B = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wr_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.outHI, 0);
        chk("rst_lo", bus.outLO, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", bus.flags, 0);
        reset_n = 1'b1;
        @(negedge clk);
        run_op(OP_MULT, 2'b00, 32'd4, 32'd8, 32'h0, 32'h20, 4'b0000, 34);
        run_op(OP_MULT, 2'b01, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4'b0000, 34);
        run_op(OP_MULT, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 4'b0100, 34);
        run_op(OP_DIV, 2'b01, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0000, 34);
        run_op(OP_DIV, 2'b00, 32'd100, 32'd7, 32'h2, 32'hE, 4'b0000, 34);
        run_op(OP_DIV, 2'b00, 32'd5, 32'd0, 32'h5, 32'hFFFF_FFFF, 4'b0001, 2);
        run_op(OP_DIV, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 4'b0010, 34);
        run_op(OP_MULT, 2'b01, 32'd0, 32'd5, 32'h0, 32'h0, 4'b1000, 34);
        bus.start = 1'b1;
        bus.operation = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("bad_op_busy", bus.busy, 0);
        repeat (40) @(negedge clk);
        chk("bad_op_hi", bus.outHI, 0);
        chk("bad_op_lo", bus.outLO, 0);
        issue(OP_MULT, 2'b00, 32'd3, 32'd3, 32'h0, 32'h9, 4'b0000, 34);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.operation = OP_DIV;
        bus.A = 32'd1;
        bus.B = 32'd1;
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        chk("busy_wr_hi", bus.outHI, 0);
        chk("busy_still", bus.busy, 1);
        wait_sb();
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.wr_lo = 1'b0;
        chk("wr_lo", bus.outLO, 32'hDEAD_BEEF);
        chk("wr_lo_hi_kept", bus.outHI, 0);
        chk("wr_lo_no_done", bus.done, 0);
        chk("wr_lo_idle", bus.busy, 0);
        bus.wr_hi = 1'b1;
        bus.wr_data = 32'h0000_1234;
        issue(OP_MULT, 2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 4'b0000, 34);
        bus.wr_hi = 1'b0;
        wait_sb();
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wr_data = 32'h55;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        chk("wr_both_hi", bus.outHI, 32'h55);
        chk("wr_both_lo", bus.outLO, 32'h55);
        bus.start = 1'b1;
        bus.operation = OP_MULT;
        bus.sign = 2'b00;
        bus.A = 32'd4;
        bus.B = 32'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_hi", bus.outHI, 0);
        chk("abort_lo", bus.outLO, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_result", bus.busy, 0);
        run_op(OP_MULT, 2'b00, 32'd4, 32'd8, 32'h0, 32'h20, 4'b0000, 34);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
